// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding, defaults and request record for the data-memory arbiter.
package dmem_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;
   localparam int DMEM_DEPTH = 10;
   localparam int DMEM_LAT = 1;
   typedef struct packed {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
   } dmem_req_t;
endpackage

// File: rtl/dmem_rr_pick.sv
// dmem_rr_pick: winner select for two requesters; round-robin when DMEM_ARB_RR_EN is defined,
// fixed priority to requester 0 otherwise.
module dmem_rr_pick (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] valid,
   input  logic       grant,
   output logic       win
);
`ifdef DMEM_ARB_RR_EN
   logic ptr;
   always_ff @(posedge clk or negedge reset)
      if (!reset) ptr <= 1'b0;
      else if (grant) ptr <= ~win;
   assign win = &valid ? ptr : valid[1];
`else
   logic unused;
   assign unused = ^{clk, reset, grant};
   assign win = ~valid[0];
`endif
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter and fixed-latency access sequencer for the single-port
// data memory. Arbitration policy is selected by DMEM_ARB_RR_EN.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int DEPTH   = DMEM_DEPTH,
   parameter int MEM_LAT = DMEM_LAT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  req_valid,
   input  logic [1:0]  req_write,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic [1:0]  req_ready,
   output logic [1:0]  rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] Mem_address,
   output logic        Mem_read,
   output logic        Mem_write,
   output logic [31:0] Write_data,
   input  logic [31:0] Read_Data
);
   state_t      state, nxt;
   dmem_req_t   cand, lat;
   logic        win, grant, bad, owner, err, issue, resp;
   logic [3:0]  cnt;
   logic [31:0] rdata;

   dmem_rr_pick u_pick (
      .clk(clk),
      .reset(reset),
      .valid(req_valid),
      .grant(grant),
      .win(win)
   );

   assign cand = win ? dmem_req_t'{req_write[1], req_addr[63:32], req_wdata[63:32]}
                     : dmem_req_t'{req_write[0], req_addr[31:0], req_wdata[31:0]};
   assign bad = cand.addr >= 32'(DEPTH);
   // gated by reset so no request is acknowledged while the latch is held clear
   assign grant = reset && state == IDLE && |req_valid;
   assign req_ready = grant ? (win ? 2'b10 : 2'b01) : 2'b00;

   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else state <= nxt;

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = grant ? (bad ? RESP : ISSUE) : IDLE;
         ISSUE:   nxt = cnt == 4'd0 ? RESP : ISSUE;
         RESP:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         lat   <= '0;
         owner <= 1'b0;
         err   <= 1'b0;
         cnt   <= 4'd0;
         rdata <= '0;
      end else if (grant) begin
         lat   <= cand;
         owner <= win;
         err   <= bad;
         cnt   <= 4'(MEM_LAT - 1);
         rdata <= '0;
      end else if (issue) begin
         cnt <= cnt == 4'd0 ? 4'd0 : cnt - 4'd1;
         if (cnt == 4'd0 && !lat.write) rdata <= Read_Data;
      end

   assign issue       = state == ISSUE;
   assign resp        = state == RESP;
   assign Mem_address = issue ? lat.addr : '0;
   assign Write_data  = issue ? lat.wdata : '0;
   assign Mem_read    = issue & ~lat.write;
   assign Mem_write   = issue & lat.write;
   assign rsp_valid   = resp ? (owner ? 2'b10 : 2'b01) : 2'b00;
   assign rsp_rdata   = resp ? rdata : '0;
   assign rsp_err     = resp & err;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter; one instance with MEM_LAT=1 and one with
// MEM_LAT=3, each with its own small memory model, selected by sel.
module tb_dmem_arbiter;
   import dmem_pkg::*;

   logic        clk = 1'b0, rst_n = 1'b0, sel = 1'b0;
   logic [1:0]  req_valid = '0, req_write = '0;
   logic [63:0] req_addr = '0, req_wdata = '0;
   logic [1:0]  v1, v3, ready1, ready3, rsp1, rsp3;
   logic [31:0] rdata1, rdata3, addr1, addr3, wd1, wd3, rdat1, rdat3;
   logic        err1, err3, rd1, rd3, wr1, wr3;
   logic [1:0]  o_ready, o_rsp;
   logic [31:0] o_rdata, o_addr, o_wdata;
   logic        o_err, o_rd, o_wr;
   logic [31:0] mem1 [0:9];
   logic [31:0] mem3 [0:9];
   logic [1:0]  exp_g [4];
   int          n_chk = 0, n_err = 0;

   always #5 clk = ~clk;

   assign v1 = sel ? 2'b00 : req_valid;
   assign v3 = sel ? req_valid : 2'b00;

   dmem_arbiter u_dut1 (
      .clk(clk), .reset(rst_n), .req_valid(v1), .req_write(req_write), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_ready(ready1), .rsp_valid(rsp1), .rsp_rdata(rdata1),
      .rsp_err(err1), .Mem_address(addr1), .Mem_read(rd1), .Mem_write(wr1),
      .Write_data(wd1), .Read_Data(rdat1)
   );

   dmem_arbiter #(.MEM_LAT(3)) u_dut3 (
      .clk(clk), .reset(rst_n), .req_valid(v3), .req_write(req_write), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_ready(ready3), .rsp_valid(rsp3), .rsp_rdata(rdata3),
      .rsp_err(err3), .Mem_address(addr3), .Mem_read(rd3), .Mem_write(wr3),
      .Write_data(wd3), .Read_Data(rdat3)
   );

   assign o_ready = sel ? ready3 : ready1;
   assign o_rsp   = sel ? rsp3 : rsp1;
   assign o_rdata = sel ? rdata3 : rdata1;
   assign o_err   = sel ? err3 : err1;
   assign o_addr  = sel ? addr3 : addr1;
   assign o_rd    = sel ? rd3 : rd1;
   assign o_wr    = sel ? wr3 : wr1;
   assign o_wdata = sel ? wd3 : wd1;

   function automatic logic [31:0] init_val(input int i);
      return (i == 0 || i == 9) ? 32'd4 : 32'h10 * i + 1;
   endfunction

   assign rdat1 = addr1 < 10 ? mem1[addr1[3:0]] : 32'd0;
   assign rdat3 = addr3 < 10 ? mem3[addr3[3:0]] : 32'd0;

   always @(posedge clk)
      if (!rst_n) begin
         for (int i = 0; i < 10; i++) begin
            mem1[i] = init_val(i);
            mem3[i] = init_val(i);
         end
      end else begin
         if (wr1 && addr1 < 10) mem1[addr1[3:0]] = wd1;
         if (wr3 && addr3 < 10) mem3[addr3[3:0]] = wd3;
      end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic xfer(input string tag, input int r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] rd_exp, input logic err_exp);
      int  ml, n, s;
      logic got, done;
      ml = sel ? 3 : 1;
      @(posedge clk); #1;
      req_valid[r] = 1'b1;
      req_write[r] = w;
      req_addr[32*r +: 32] = a;
      req_wdata[32*r +: 32] = d;
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
         @(negedge clk);
         got = o_ready[r];
      end
      check({tag, "_ready"}, o_ready, r == 1 ? 2'b10 : 2'b01);
      @(posedge clk); #1;
      req_valid[r] = 1'b0;
      s = 0;
      n = 0;
      done = 1'b0;
      for (int k = 1; k <= 20 && !done; k++) begin
         @(negedge clk);
         n = k;
         if (o_rd | o_wr) begin
            s++;
            check({tag, "_bus"}, {o_addr, o_wdata, o_rd, o_wr}, {a, d, ~w, w});
         end
         done = |o_rsp;
      end
      check({tag, "_lat"}, n, err_exp ? 1 : ml + 1);
      check({tag, "_strobes"}, s, err_exp ? 0 : ml);
      check({tag, "_rsp"}, {o_rsp, o_rdata, o_err}, {(r == 1 ? 2'b10 : 2'b01), rd_exp, err_exp});
      @(negedge clk);
      check({tag, "_rsp_end"}, o_rsp, 2'b00);
   endtask

   initial begin
      logic       got, seen;
      logic [1:0] g;
`ifdef DMEM_ARB_RR_EN
      exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
      exp_g = '{2'b01, 2'b01, 2'b01, 2'b10};
`endif
      // requests presented during reset must not be acknowledged
      req_valid = 2'b01;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_outs", {o_ready, o_rsp, o_rdata, o_err, o_addr, o_rd, o_wr, o_wdata}, '0);
      check("rst_state", u_dut1.state, IDLE);
      req_valid = 2'b00;
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         seen |= |o_ready;
      end
      check("idle_noready", seen, 1'b0);
      check("idle_state", u_dut1.state, IDLE);

      xfer("st3", 0, 1'b1, 32'd3, 32'hA5, 32'd0, 1'b0);
      xfer("ld3", 0, 1'b0, 32'd3, 32'd0, 32'hA5, 1'b0);
      xfer("st5_r1", 1, 1'b1, 32'd5, 32'h1234_5678, 32'd0, 1'b0);
      xfer("ld5_r1", 1, 1'b0, 32'd5, 32'd0, 32'h1234_5678, 1'b0);

      // fresh pointer for contention
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      req_write = 2'b00;
      req_addr = '0;
      req_wdata = '0;
      req_valid = 2'b11;
      for (int rd = 0; rd < 4; rd++) begin
         got = 1'b0;
         g = 2'b00;
         for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            got = |o_ready;
            g = o_ready;
         end
         check("cont_grant", g, exp_g[rd]);
         got = 1'b0;
         for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            got = |o_rsp;
         end
         check("cont_rsp", {o_rsp, o_rdata, o_err}, {exp_g[rd], 32'd4, 1'b0});
         @(posedge clk); #1;
         req_valid[0] = rd < 2;
      end
      req_valid = 2'b00;

      xfer("oor10", 0, 1'b0, 32'd10, 32'd0, 32'd0, 1'b1);
      xfer("oor16", 1, 1'b0, 32'h10, 32'd0, 32'd0, 1'b1);
      xfer("oor_hi", 0, 1'b1, 32'h8000_0009, 32'h55, 32'd0, 1'b1);
      xfer("ld9", 0, 1'b0, 32'd9, 32'd0, 32'd4, 1'b0);

      sel = 1'b1;
      xfer("l3_ld3", 0, 1'b0, 32'd3, 32'd0, 32'h31, 1'b0);
      xfer("l3_st7", 1, 1'b1, 32'd7, 32'hDEAD_BEEF, 32'd0, 1'b0);
      xfer("l3_ld7", 1, 1'b0, 32'd7, 32'd0, 32'hDEAD_BEEF, 1'b0);

      // abort a load in its second memory cycle
      @(posedge clk); #1;
      req_valid[0] = 1'b1;
      req_write[0] = 1'b0;
      req_addr[31:0] = 32'd2;
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
         @(negedge clk);
         got = o_ready[0];
      end
      check("mid_grant", got, 1'b1);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      @(posedge clk); #2;
      check("mid_pre", {o_rd, o_addr}, {1'b1, 32'd2});
      rst_n = 1'b0;
      #1;
      check("mid_abort", {o_rd, o_wr, o_addr}, '0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         seen |= |o_rsp;
      end
      check("mid_norsp", seen, 1'b0);
      xfer("post_rst", 0, 1'b0, 32'd9, 32'd0, 32'd4, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
